pfvf_rtable_ctrl: RTL and testbench
===================================

Name: pfvf_rtable_ctrl

Overview:
- Runtime-programmable PF/VF routing-table controller for the PF/VF mux.
- Holds NUM_ENTRIES routing entries, written through a simple config port.
- Services lookup requests carrying a TLP's {pf, vf, vf_active} by scanning entries one per cycle, lowest index first, and returns the mux port ID (PID) of the first match, or DEF_PID on a miss.
- Sits between the mux's header decode and its port-select logic; also counts misses for a CSR.

Parameters:
- NUM_ENTRIES, 4: routing-table depth; minimum 2.
- PF_WIDTH, 3: PF number width.
- VF_WIDTH, 11: VF number width.
- PID_WIDTH, 1: mux port ID width.
- TAG_WIDTH, 8: opaque request tag, returned unchanged.
- DEF_PID, 0: PID returned on miss.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_wr_en  in  1  config write strobe
- cfg_wr_ready  out  1  config write accepted when cfg_wr_en & cfg_wr_ready
- cfg_wr_idx  in  $clog2(NUM_ENTRIES)  entry index
- cfg_wr_valid  in  1  entry-enable bit to store
- cfg_wr_pf  in  PF_WIDTH  PF to store; all-ones = wildcard
- cfg_wr_vf  in  VF_WIDTH  VF to store; all-ones = wildcard
- cfg_wr_vf_active  in  1  VF-active to store
- cfg_wr_pid  in  PID_WIDTH  PID to store
- req_valid  in  1  lookup request valid
- req_ready  out  1  lookup request ready
- req_pf  in  PF_WIDTH  request PF
- req_vf  in  VF_WIDTH  request VF
- req_vf_active  in  1  request VF-active
- req_tag  in  TAG_WIDTH  request tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_pid  out  PID_WIDTH  selected PID
- rsp_hit  out  1  1 = matched an entry, 0 = default
- rsp_idx  out  $clog2(NUM_ENTRIES)  matched index; 0 on miss
- rsp_tag  out  TAG_WIDTH  echoed tag
- miss_cnt  out  16  saturating miss counter

Behaviour:
- Reset: state IDLE; all entries invalid with fields cleared.
- Reset values of outputs:
  - req_ready=1, cfg_wr_ready=1.
  - rsp_valid=0, rsp_pid=0, rsp_hit=0, rsp_idx=0, rsp_tag=0.
  - miss_cnt=0.
- Reset mid-scan or mid-response aborts the operation; no response is produced.
- Entry match rule (all conditions must hold):
  - Entry is valid.
  - pf field is all-ones, or equals req_pf.
  - vf_active field equals req_vf_active.
  - When req_vf_active=1: vf field is all-ones, or equals req_vf. VF is ignored when req_vf_active=0.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: req_ready=1. On req_valid & req_ready (cycle 0), capture the request, set scan index i=0, go to SCAN.
  - SCAN: req_ready=0. Evaluate entry i in cycle i+1.
    - Match at entry k: latch pid, hit=1, idx=k; go to RESP. rsp_valid rises in cycle k+2.
    - No match with i=NUM_ENTRIES-1: latch pid=DEF_PID, hit=0, idx=0; increment miss_cnt (saturates at 0xFFFF); go to RESP. rsp_valid rises in cycle NUM_ENTRIES+1.
    - Otherwise i increments.
  - RESP: rsp_valid=1 with all rsp_* fields stable until rsp_ready.
    - On rsp_valid & rsp_ready, drop rsp_valid the next cycle and return to IDLE.
    - req_ready is re-asserted in the cycle after the response handshake. No request overlap.
- Latency: best case 2 cycles from request acceptance to rsp_valid; worst case NUM_ENTRIES+1. Throughput: one lookup in flight.
- Config writes:
  - cfg_wr_ready = (state != SCAN), so the table is stable during a scan.
  - An accepted write updates the entry on the next clock edge and is visible to any lookup accepted in the same or a later cycle.
  - A write accepted in the same cycle as a request acceptance applies before that request's scan begins.
  - Writes during RESP do not alter the held response.
  - A write to an index >= NUM_ENTRIES (non-power-of-2 depth only) is accepted and discarded.
- Priority: lower index wins when several entries match.
- Wildcard all-ones in both pf and vf with vf_active=1 is the intended catch-all VF default entry.

Test Plan:
- Reset, no writes; request pf=2 vf_active=0 tag=0x5A -> rsp_valid 5 cycles after accept (NUM_ENTRIES=4), hit=0, pid=DEF_PID=0, tag=0x5A, miss_cnt=1.
- Entry0={pf=0,vf=0,vfa=0,pid=0}, entry1={pf=0,vf=0,vfa=1,pid=1}; request pf=0 vf=0 vfa=1 -> rsp_valid at cycle 3, hit=1, idx=1, pid=1. Request pf=0 vfa=0 vf=7 -> idx=0, pid=0 at cycle 2.
- Entry2={pf=7,vf=0x7FF,vfa=1,pid=1} wildcard; request pf=3 vf=0x123 vfa=1 -> idx=2, pid=1. Same entry with request vfa=0 -> miss.
- Hold rsp_ready=0 for 10 cycles -> rsp_* stable; req_ready=0 and cfg_wr_ready=1 during RESP; cfg write to the matched entry leaves the held response unchanged.
- Assert rst during SCAN -> next cycle rsp_valid=0, req_ready=1, all entries invalid; subsequent lookup misses.
- Preload miss_cnt to 0xFFFF via 65535 misses (or force) -> one more miss keeps miss_cnt=0xFFFF.

Source files
------------

// File: rtl/pfvf_rtable_ctrl.sv
// PF/VF routing-table controller: programmable match entries scanned one per
// cycle, lowest index first, returning the PID of the first match or a default.
module pfvf_rtable_ctrl #(
  parameter int NUM_ENTRIES = 4,
  parameter int PF_WIDTH    = 3,
  parameter int VF_WIDTH    = 11,
  parameter int PID_WIDTH   = 1,
  parameter int TAG_WIDTH   = 8,
  parameter int DEF_PID     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_wr_en,
  output logic                           cfg_wr_ready,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_wr_idx,
  input  logic                           cfg_wr_valid,
  input  logic [PF_WIDTH-1:0]            cfg_wr_pf,
  input  logic [VF_WIDTH-1:0]            cfg_wr_vf,
  input  logic                           cfg_wr_vf_active,
  input  logic [PID_WIDTH-1:0]           cfg_wr_pid,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [PF_WIDTH-1:0]            req_pf,
  input  logic [VF_WIDTH-1:0]            req_vf,
  input  logic                           req_vf_active,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [PID_WIDTH-1:0]           rsp_pid,
  output logic                           rsp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0] rsp_idx,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic [15:0]                    miss_cnt
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [IDX_W-1:0]     scan_idx_r;
  logic [PF_WIDTH-1:0]  req_pf_r;
  logic [VF_WIDTH-1:0]  req_vf_r;
  logic                 req_vfa_r;
  logic [TAG_WIDTH-1:0] req_tag_r;
  logic                 hit_s;
  logic                 last_s;
  logic                 accept_s;

  logic                 tbl_valid_r [NUM_ENTRIES];
  logic [PF_WIDTH-1:0]  tbl_pf_r    [NUM_ENTRIES];
  logic [VF_WIDTH-1:0]  tbl_vf_r    [NUM_ENTRIES];
  logic                 tbl_vfa_r   [NUM_ENTRIES];
  logic [PID_WIDTH-1:0] tbl_pid_r   [NUM_ENTRIES];

  // All-ones in pf/vf is a wildcard; vf only matters for VF-active requests.
  function automatic logic entry_match(
    input logic                v,
    input logic [PF_WIDTH-1:0] epf,
    input logic [VF_WIDTH-1:0] evf,
    input logic                evfa,
    input logic [PF_WIDTH-1:0] rpf,
    input logic [VF_WIDTH-1:0] rvf,
    input logic                rvfa
  );
    logic pf_ok;
    logic vf_ok;
    pf_ok = (epf == {PF_WIDTH{1'b1}}) || (epf == rpf);
    vf_ok = !rvfa || (evf == {VF_WIDTH{1'b1}}) || (evf == rvf);
    return v && pf_ok && (evfa == rvfa) && vf_ok;
  endfunction

  // Next-state decode and evaluation of the entry under scan.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = req_valid && req_ready;
    last_s     = (scan_idx_r == IDX_W'(NUM_ENTRIES - 1));
    hit_s      = entry_match(tbl_valid_r[scan_idx_r], tbl_pf_r[scan_idx_r],
                             tbl_vf_r[scan_idx_r], tbl_vfa_r[scan_idx_r],
                             req_pf_r, req_vf_r, req_vfa_r);
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = SCAN;
        else          state_nx_s = IDLE;
      end
      SCAN: begin
        if (hit_s || last_s) state_nx_s = RESP;
        else                 state_nx_s = SCAN;
      end
      RESP: begin
        if (rsp_ready) state_nx_s = IDLE;
        else           state_nx_s = RESP;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, request capture, scan index, registered response and miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      scan_idx_r   <= '0;
      req_pf_r     <= '0;
      req_vf_r     <= '0;
      req_vfa_r    <= 1'b0;
      req_tag_r    <= '0;
      req_ready    <= 1'b1;
      cfg_wr_ready <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_pid      <= '0;
      rsp_hit      <= 1'b0;
      rsp_idx      <= '0;
      rsp_tag      <= '0;
      miss_cnt     <= 16'h0000;
    end else begin
      state_r      <= state_nx_s;
      req_ready    <= (state_nx_s == IDLE);
      cfg_wr_ready <= (state_nx_s != SCAN);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_pf_r   <= req_pf;
            req_vf_r   <= req_vf;
            req_vfa_r  <= req_vf_active;
            req_tag_r  <= req_tag;
            scan_idx_r <= '0;
          end
        end
        SCAN: begin
          if (hit_s) begin
            rsp_valid <= 1'b1;
            rsp_pid   <= tbl_pid_r[scan_idx_r];
            rsp_hit   <= 1'b1;
            rsp_idx   <= scan_idx_r;
            rsp_tag   <= req_tag_r;
          end else if (last_s) begin
            rsp_valid <= 1'b1;
            rsp_pid   <= PID_WIDTH'(DEF_PID);
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_tag   <= req_tag_r;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
          end else begin
            scan_idx_r <= scan_idx_r + IDX_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

  // Routing table; writes are only accepted outside SCAN, out-of-range indices drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tbl_valid_r[e] <= 1'b0;
        tbl_pf_r[e]    <= '0;
        tbl_vf_r[e]    <= '0;
        tbl_vfa_r[e]   <= 1'b0;
        tbl_pid_r[e]   <= '0;
      end
    end else if (cfg_wr_en && cfg_wr_ready) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (cfg_wr_idx == IDX_W'(e)) begin
          tbl_valid_r[e] <= cfg_wr_valid;
          tbl_pf_r[e]    <= cfg_wr_pf;
          tbl_vf_r[e]    <= cfg_wr_vf;
          tbl_vfa_r[e]   <= cfg_wr_vf_active;
          tbl_pid_r[e]   <= cfg_wr_pid;
        end
      end
    end
  end

endmodule

// File: tb/tb_pfvf_rtable_ctrl.sv
// Directed self-checking bench for pfvf_rtable_ctrl (default parameters, 4 entries).
module tb_pfvf_rtable_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic        cfg_wr_ready;
  logic [1:0]  cfg_wr_idx;
  logic        cfg_wr_valid;
  logic [2:0]  cfg_wr_pf;
  logic [10:0] cfg_wr_vf;
  logic        cfg_wr_vf_active;
  logic [0:0]  cfg_wr_pid;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_pf;
  logic [10:0] req_vf;
  logic        req_vf_active;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_pid;
  logic        rsp_hit;
  logic [1:0]  rsp_idx;
  logic [7:0]  rsp_tag;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pfvf_rtable_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_pf(cfg_wr_pf), .cfg_wr_vf(cfg_wr_vf),
    .cfg_wr_vf_active(cfg_wr_vf_active), .cfg_wr_pid(cfg_wr_pid),
    .req_valid(req_valid), .req_ready(req_ready), .req_pf(req_pf), .req_vf(req_vf),
    .req_vf_active(req_vf_active), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pid(rsp_pid), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .rsp_tag(rsp_tag), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [2:0] pf,
                           input logic [10:0] vf, input logic vfa, input logic [0:0] pid);
    cfg_wr_idx = idx; cfg_wr_valid = v; cfg_wr_pf = pf; cfg_wr_vf = vf;
    cfg_wr_vf_active = vfa; cfg_wr_pid = pid; cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  // Called in the cycle after acceptance; measures latency in cycles from acceptance.
  task automatic wait_rsp(input string name, input int lat, input logic hit,
                          input logic [1:0] idx, input logic [0:0] pid,
                          input logic [7:0] tag, input logic ack);
    int c;
    chk({name, ".scan_req_ready"}, 32'(req_ready), 32'd0);
    chk({name, ".scan_cfg_ready"}, 32'(cfg_wr_ready), 32'd0);
    c = 1;
    while (rsp_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    chk({name, ".latency"}, 32'(c), 32'(lat));
    chk({name, ".hit"}, 32'(rsp_hit), 32'(hit));
    chk({name, ".idx"}, 32'(rsp_idx), 32'(idx));
    chk({name, ".pid"}, 32'(rsp_pid), 32'(pid));
    chk({name, ".tag"}, 32'(rsp_tag), 32'(tag));
    if (ack) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({name, ".post_valid"}, 32'(rsp_valid), 32'd0);
      chk({name, ".post_req_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic lookup(input string name, input logic [2:0] pf, input logic [10:0] vf,
                        input logic vfa, input logic [7:0] tag, input int lat,
                        input logic hit, input logic [1:0] idx, input logic [0:0] pid,
                        input logic ack);
    req_pf = pf; req_vf = vf; req_vf_active = vfa; req_tag = tag; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(name, lat, hit, idx, pid, tag, ack);
  endtask

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_idx = 2'd0; cfg_wr_valid = 1'b0;
    cfg_wr_pf = 3'd0; cfg_wr_vf = 11'd0; cfg_wr_vf_active = 1'b0; cfg_wr_pid = 1'b0;
    req_valid = 1'b0; req_pf = 3'd0; req_vf = 11'd0; req_vf_active = 1'b0;
    req_tag = 8'd0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.cfg_wr_ready", 32'(cfg_wr_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_pid", 32'(rsp_pid), 32'd0);
    chk("reset.rsp_hit", 32'(rsp_hit), 32'd0);
    chk("reset.rsp_idx", 32'(rsp_idx), 32'd0);
    chk("reset.rsp_tag", 32'(rsp_tag), 32'd0);
    chk("reset.miss_cnt", 32'(miss_cnt), 32'd0);

    // Empty table: full scan then default response.
    lookup("empty_miss", 3'd2, 11'd0, 1'b0, 8'h5A, 5, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("empty_miss.miss_cnt", 32'(miss_cnt), 32'd1);

    cfg_write(2'd0, 1'b1, 3'd0, 11'd0, 1'b0, 1'b0);
    cfg_write(2'd1, 1'b1, 3'd0, 11'd0, 1'b1, 1'b1);
    lookup("vfa1_e1", 3'd0, 11'd0, 1'b1, 8'h11, 3, 1'b1, 2'd1, 1'b1, 1'b1);
    lookup("vfa0_e0", 3'd0, 11'd7, 1'b0, 8'h22, 2, 1'b1, 2'd0, 1'b0, 1'b1);
    chk("hits.miss_cnt", 32'(miss_cnt), 32'd1);

    cfg_write(2'd2, 1'b1, 3'd7, 11'h7FF, 1'b1, 1'b1);
    lookup("wild_e2", 3'd3, 11'h123, 1'b1, 8'h33, 4, 1'b1, 2'd2, 1'b1, 1'b1);
    lookup("wild_vfa0", 3'd3, 11'h123, 1'b0, 8'h44, 5, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("wild_vfa0.miss_cnt", 32'(miss_cnt), 32'd2);

    // Held response is stable under backpressure and a write to the matched entry.
    lookup("hold", 3'd3, 11'h123, 1'b1, 8'h77, 4, 1'b1, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold.rsp_pid", 32'(rsp_pid), 32'd1);
      chk("hold.rsp_idx", 32'(rsp_idx), 32'd2);
      chk("hold.rsp_tag", 32'(rsp_tag), 32'h77);
      chk("hold.req_ready", 32'(req_ready), 32'd0);
      chk("hold.cfg_wr_ready", 32'(cfg_wr_ready), 32'd1);
      if (i == 3) begin
        cfg_wr_idx = 2'd2; cfg_wr_valid = 1'b1; cfg_wr_pf = 3'd7; cfg_wr_vf = 11'h7FF;
        cfg_wr_vf_active = 1'b1; cfg_wr_pid = 1'b0; cfg_wr_en = 1'b1;
      end else begin
        cfg_wr_en = 1'b0;
      end
      tick();
    end
    cfg_wr_en = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold.post_valid", 32'(rsp_valid), 32'd0);
    chk("hold.post_req_ready", 32'(req_ready), 32'd1);
    lookup("after_hold_wr", 3'd3, 11'h123, 1'b1, 8'h78, 4, 1'b1, 2'd2, 1'b0, 1'b1);

    // Write accepted together with the request applies before its scan.
    cfg_wr_idx = 2'd0; cfg_wr_valid = 1'b1; cfg_wr_pf = 3'd3; cfg_wr_vf = 11'h123;
    cfg_wr_vf_active = 1'b1; cfg_wr_pid = 1'b1; cfg_wr_en = 1'b1;
    req_pf = 3'd3; req_vf = 11'h123; req_vf_active = 1'b1; req_tag = 8'h99; req_valid = 1'b1;
    tick();
    cfg_wr_en = 1'b0; req_valid = 1'b0;
    wait_rsp("same_cycle_wr", 2, 1'b1, 2'd0, 1'b1, 8'h99, 1'b1);

    // Reset in the middle of a scan aborts the lookup and clears the table.
    req_pf = 3'd5; req_vf = 11'd0; req_vf_active = 1'b0; req_tag = 8'hAB; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midscan_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midscan_rst.req_ready", 32'(req_ready), 32'd1);
    chk("midscan_rst.miss_cnt", 32'(miss_cnt), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("midscan_rst.no_rsp", 32'(rsp_valid), 32'd0);
    lookup("post_rst_miss", 3'd3, 11'h123, 1'b1, 8'h42, 5, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("post_rst_miss.miss_cnt", 32'(miss_cnt), 32'd1);

    // Saturation of the miss counter.
    force dut.miss_cnt = 16'hFFFE;
    #1;
    release dut.miss_cnt;
    chk("sat.preload", 32'(miss_cnt), 32'hFFFE);
    lookup("sat_miss1", 3'd1, 11'd0, 1'b0, 8'h01, 5, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("sat.reach", 32'(miss_cnt), 32'hFFFF);
    lookup("sat_miss2", 3'd1, 11'd0, 1'b0, 8'h02, 5, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("sat.hold", 32'(miss_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
